// File: rtl/exp_arb_pkg.sv
// Shared definitions for the exponent-engine arbiter and the engine's users.
//   arb_state_t : 2-bit FSM state encoding of the arbiter
//   Q4_27_ONE   : 1.0 in the Q4.27 format the exponent engine works in
//   FRAC_BITS   : number of fractional bits of that format
package exp_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_WAIT   = 2'd2,
      S_RETURN = 2'd3
   } arb_state_t;

   localparam logic [31:0] Q4_27_ONE = 32'h0800_0000;
   localparam int          FRAC_BITS = 27;

endpackage

// File: rtl/exp_engine_arbiter_if.sv
// Bundle of requester-side and engine-side signals of the exponent arbiter.
//   req_valid/req_ready/req_data : per-requester command channel (NREQ lanes)
//   rsp_valid/rsp_ready          : per-requester result handshake
//   rsp_data/rsp_err             : result shared by all requesters
//   eng_cmd_*                    : command channel to the exponent engine
//   eng_rsp_*                    : result channel from the exponent engine
//   busy/drop_count              : status
// modport slave  : the arbiter's view
// modport master : the environment's view (requesters + engine)
interface exp_engine_arbiter_if #(
   parameter int NREQ = 4,
   parameter int DW   = 32,
   parameter int CW   = 16
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    rsp_valid;
   logic [NREQ-1:0]    rsp_ready;
   logic [DW-1:0]      rsp_data;
   logic               rsp_err;
   logic               eng_cmd_valid;
   logic               eng_cmd_ready;
   logic [DW-1:0]      eng_cmd_data;
   logic               eng_rsp_valid;
   logic               eng_rsp_ready;
   logic [DW-1:0]      eng_rsp_data;
   logic               busy;
   logic [CW-1:0]      drop_count;

   modport slave (
      input  req_valid, req_data, rsp_ready, eng_cmd_ready, eng_rsp_valid, eng_rsp_data,
      output req_ready, rsp_valid, rsp_data, rsp_err, eng_cmd_valid, eng_cmd_data,
             eng_rsp_ready, busy, drop_count
   );

   modport master (
      output req_valid, req_data, rsp_ready, eng_cmd_ready, eng_rsp_valid, eng_rsp_data,
      input  req_ready, rsp_valid, rsp_data, rsp_err, eng_cmd_valid, eng_cmd_data,
             eng_rsp_ready, busy, drop_count
   );
endinterface

// File: rtl/exp_engine_arbiter_rr_pick.sv
// Combinational round-robin priority picker.
//   req : request vector
//   ptr : index with highest priority this cycle; priority falls off upward modulo N
//   gnt : one-hot grant (zero when no request)
//   idx : index of the granted request
//   any : at least one request present
module rr_pick #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   always_comb begin
      logic [IW:0] pos;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      pos = '0;
      // Scan from the farthest position back to ptr so the nearest requester
      // is the last one written and therefore wins.
      for (int k = N - 1; k >= 0; k--) begin
         pos = {1'b0, ptr} + (IW+1)'(k);
         if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
         if (req[pos[IW-1:0]]) begin
            gnt               = '0;
            gnt[pos[IW-1:0]]  = 1'b1;
            idx               = pos[IW-1:0];
            any               = 1'b1;
         end
      end
   end

endmodule

// File: rtl/exp_engine_arbiter.sv
// Shares one exponent engine among NREQ requesters with round-robin
// arbitration and a single operation in flight. The granted operand is
// forwarded to the engine and the result is routed back to the same
// requester. A watchdog aborts an engine operation that takes too long and
// returns a zero result flagged with rsp_err; a late result of such an
// aborted operation is discarded and counted in drop_count.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : exp_engine_arbiter_if.slave (requester and engine channels, status)
// Parameters: NREQ requesters (2..8), DW data width, TIMEOUT watchdog limit
// in WAIT cycles (0 disables it), CW width of drop_count.
module exp_engine_arbiter
   import exp_arb_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int DW      = 32,
   parameter int TIMEOUT = 64,
   parameter int CW      = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   exp_engine_arbiter_if.slave  bus
);

   localparam int IW = $clog2(NREQ);
   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   arb_state_t      state;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   grant;
   logic [TW-1:0]   timer;
   logic [DW-1:0]   op_reg;
   logic [DW-1:0]   res_reg;
   logic            err_reg;
   logic [CW-1:0]   drop_cnt;

   logic [NREQ-1:0] pick_gnt;
   logic [IW-1:0]   pick_idx;
   logic            pick_any;
   logic [NREQ-1:0] grant_oh;
   logic [DW-1:0]   op_sel;
   logic            rsp_hs;
   logic            stale;
   logic            timed_out;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == {CW{1'b1}}) ? v : v + 1'b1;
   endfunction

   rr_pick #(.N(NREQ)) u_pick (
      .req (bus.req_valid),
      .ptr (rr_ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   always_comb begin
      op_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick_gnt[i]) op_sel = bus.req_data[i*DW +: DW];
      end
   end

   assign grant_oh  = NREQ'(1) << grant;
   assign rsp_hs    = (state == S_RETURN) && ((bus.rsp_ready & grant_oh) != '0);
   // A result seen outside WAIT can only belong to an operation the watchdog
   // already gave up on.
   assign stale     = bus.eng_rsp_valid && ((state == S_IDLE) || (state == S_ISSUE));
   assign timed_out = (TIMEOUT != 0) && (timer == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         rr_ptr   <= '0;
         grant    <= '0;
         timer    <= '0;
         op_reg   <= '0;
         res_reg  <= '0;
         err_reg  <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (stale) drop_cnt <= sat_inc(drop_cnt);
         // Only WAIT counts; everywhere else the timer sits at zero.
         if (state != S_WAIT) timer <= '0;
         case (state)
            S_IDLE: begin
               if (pick_any) begin
                  op_reg <= op_sel;
                  grant  <= pick_idx;
                  state  <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (bus.eng_cmd_ready) state <= S_WAIT;
            end
            S_WAIT: begin
               timer <= timer + 1'b1;
               // A result on the timeout cycle still counts as a good result.
               if (bus.eng_rsp_valid) begin
                  res_reg <= bus.eng_rsp_data;
                  err_reg <= 1'b0;
                  state   <= S_RETURN;
               end else if (timed_out) begin
                  res_reg <= '0;
                  err_reg <= 1'b1;
                  state   <= S_RETURN;
               end
            end
            S_RETURN: begin
               if (rsp_hs) begin
                  rr_ptr <= (grant == IW'(NREQ - 1)) ? '0 : grant + 1'b1;
                  state  <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Handshake strobes are forced low while reset is held so nothing is
   // accepted from either side during reset.
   assign bus.req_ready     = (!reset && state == S_IDLE) ? pick_gnt : '0;
   assign bus.rsp_valid     = (state == S_RETURN) ? grant_oh : '0;
   assign bus.rsp_data      = res_reg;
   assign bus.rsp_err       = err_reg;
   assign bus.eng_cmd_valid = (state == S_ISSUE);
   assign bus.eng_cmd_data  = op_reg;
   assign bus.eng_rsp_ready = !reset && (state != S_RETURN);
   assign bus.busy          = (state != S_IDLE);
   assign bus.drop_count    = drop_cnt;

endmodule

// File: tb/tb_exp_engine_arbiter.sv
// Scoreboard bench for exp_engine_arbiter with a stub engine returning the
// bitwise complement of its operand after a programmable latency.
module tb_exp_engine_arbiter;
   import exp_arb_pkg::*;

   localparam int NREQ    = 4;
   localparam int DW      = 32;
   localparam int TIMEOUT = 8;
   localparam int CW      = 16;

   typedef struct {
      int          idx;
      logic [31:0] data;
      logic        err;
      int          cyc;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [3:0]  rv;
   logic [31:0] rd [4];
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;
   int          stub_lat;
   int          stale_pulses;
   exp_t        sb [$];

   exp_engine_arbiter_if #(.NREQ(NREQ), .DW(DW), .CW(CW)) bus ();

   exp_engine_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.req_valid = rv;
   assign bus.req_data  = {rd[3], rd[2], rd[1], rd[0]};

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
      end
   endtask

   task automatic fail(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: got no event, expected one within the cycle budget", nm);
   endtask

   // Drive point: 1 time unit after the falling edge.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic push_exp(input int i, input logic [31:0] d, input logic e, input int c);
      exp_t x;
      x.idx = i; x.data = d; x.err = e; x.cyc = c;
      sb.push_back(x);
   endtask

   // Raise a request and hold it until granted; optionally queue the expected
   // response with its first-valid cycle (lat < 0: cycle not checked).
   task automatic send(input int i, input logic [31:0] d, input logic [31:0] ed,
                       input logic ee, input int lat, input bit push);
      bit got;
      int t0;
      got = 1'b0;
      t0  = 0;
      rv[i] = 1'b1;
      rd[i] = d;
      for (int n = 0; n < 200 && !got; n++) begin
         #2;
         if (bus.req_ready[i]) begin
            got = 1'b1;
            t0  = cyc;
            chk($sformatf("req_ready_%0d", i), 64'(bus.req_ready), 64'(4'b0001 << i));
         end
         step();
      end
      rv[i] = 1'b0;
      if (!got) fail($sformatf("grant_timeout_%0d", i));
      else if (push) push_exp(i, ed, ee, (lat >= 0) ? t0 + lat : -1);
   endtask

   task automatic wait_idle(input string nm);
      bit done;
      done = 1'b0;
      for (int n = 0; n < 300 && !done; n++) begin
         #2;
         if (sb.size() == 0 && !bus.busy) done = 1'b1;
         step();
      end
      if (!done) fail(nm);
   endtask

   // Stub engine: accepts commands per eng_cmd_ready (driven by the main
   // process) and answers ~operand stub_lat cycles after the handshake.
   initial begin
      int          rsp_cd;
      logic [31:0] rsp_val;
      int          stale_done;
      rsp_cd = -1;
      rsp_val = '0;
      stale_done = 0;
      bus.eng_rsp_valid = 1'b0;
      bus.eng_rsp_data  = '0;
      forever begin
         @(negedge clk);
         #2;
         bus.eng_rsp_valid = 1'b0;
         if (rsp_cd > 0) rsp_cd--;
         if (rsp_cd == 0) begin
            bus.eng_rsp_valid = 1'b1;
            bus.eng_rsp_data  = rsp_val;
            rsp_cd = -1;
         end else if (stale_done != stale_pulses) begin
            bus.eng_rsp_valid = 1'b1;
            bus.eng_rsp_data  = 32'hDEAD_BEEF;
            stale_done++;
         end
         if (bus.eng_cmd_valid && bus.eng_cmd_ready && stub_lat > 0 && rsp_cd < 0) begin
            rsp_cd  = stub_lat;
            rsp_val = ~bus.eng_cmd_data;
         end
      end
   end

   // Monitor: pops the scoreboard on every response handshake and checks that
   // a stalled response holds steady.
   initial begin
      bit          prev_vld;
      logic [3:0]  prev_vec;
      logic [31:0] prev_data;
      logic        prev_err;
      int          start_cyc;
      exp_t        e;
      prev_vld = 1'b0; prev_vec = '0; prev_data = '0; prev_err = 1'b0; start_cyc = 0;
      forever begin
         @(negedge clk);
         #2;
         if (reset || bus.rsp_valid == '0) begin
            prev_vld = 1'b0;
         end else begin
            if (!prev_vld) start_cyc = cyc;
            else begin
               chk("rsp_hold_valid", 64'(bus.rsp_valid), 64'(prev_vec));
               chk("rsp_hold_data", 64'(bus.rsp_data), 64'(prev_data));
               chk("rsp_hold_err", 64'(bus.rsp_err), 64'(prev_err));
            end
            if ((bus.rsp_valid & bus.rsp_ready) != '0) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL rsp_unexpected: got rsp_valid=0x%0h data=0x%0h, expected none",
                           bus.rsp_valid, bus.rsp_data);
               end else begin
                  e = sb.pop_front();
                  chk("rsp_sel", 64'(bus.rsp_valid), 64'(4'b0001 << e.idx));
                  chk("rsp_data", 64'(bus.rsp_data), 64'(e.data));
                  chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                  if (e.cyc >= 0) chk("rsp_cycle", 64'(start_cyc), 64'(e.cyc));
               end
               prev_vld = 1'b0;
            end else begin
               prev_vld  = 1'b1;
               prev_vec  = bus.rsp_valid;
               prev_data = bus.rsp_data;
               prev_err  = bus.rsp_err;
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: got no finish, expected finish before time limit");
      $fatal(1, "bench time limit");
   end

   initial begin
      reset = 1'b1;
      rv = '0;
      for (int i = 0; i < 4; i++) rd[i] = '0;
      bus.rsp_ready     = 4'b1111;
      bus.eng_cmd_ready = 1'b1;
      stub_lat     = 5;
      stale_pulses = 0;

      // Reset state
      step(); step(); #2;
      chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      chk("rst_eng_cmd_valid", 64'(bus.eng_cmd_valid), 64'(0));
      chk("rst_eng_rsp_ready", 64'(bus.eng_rsp_ready), 64'(0));
      chk("rst_busy", 64'(bus.busy), 64'(0));
      chk("rst_drop", 64'(bus.drop_count), 64'(0));
      step();
      reset = 1'b0;
      #2;
      chk("idle_eng_rsp_ready", 64'(bus.eng_rsp_ready), 64'(1));
      chk("idle_busy", 64'(bus.busy), 64'(0));
      step();

      // Fairness: all four at once, then requester 0 again behind 3
      push_exp(0, 32'hFFFF_FFEF, 1'b0, -1);
      push_exp(1, 32'hFFFF_FFDF, 1'b0, -1);
      push_exp(2, 32'hFFFF_FFCF, 1'b0, -1);
      push_exp(3, 32'hFFFF_FFBF, 1'b0, -1);
      push_exp(0, 32'hFFFF_FFAF, 1'b0, -1);
      fork
         begin
            send(0, 32'h10, 32'h0, 1'b0, -1, 1'b0);
            send(0, 32'h50, 32'h0, 1'b0, -1, 1'b0);
         end
         send(1, 32'h20, 32'h0, 1'b0, -1, 1'b0);
         send(2, 32'h30, 32'h0, 1'b0, -1, 1'b0);
         send(3, 32'h40, 32'h0, 1'b0, -1, 1'b0);
      join
      wait_idle("fair_idle");

      // Single requester, L=5: result first valid 7 cycles after the grant
      send(2, Q4_27_ONE, 32'hF7FF_FFFF, 1'b0, 7, 1'b1);
      wait_idle("single_idle");

      // Watchdog abort, then the late result arrives while idle
      stub_lat = -1;
      send(1, 32'h0800_0000, 32'h0, 1'b1, 10, 1'b1);
      wait_idle("timeout_idle");
      stale_pulses = stale_pulses + 1;
      step(); step(); #2;
      chk("stale_drop", 64'(bus.drop_count), 64'(1));
      chk("stale_no_rsp", 64'(bus.rsp_valid), 64'(0));
      chk("stale_busy", 64'(bus.busy), 64'(0));
      step();
      stub_lat = 5;

      // Engine not ready for 4 cycles in ISSUE
      bus.eng_cmd_ready = 1'b0;
      send(0, 32'h0000_0100, 32'hFFFF_FEFF, 1'b0, 11, 1'b1);
      for (int k = 0; k < 4; k++) begin
         #2;
         chk("issue_cmd_valid", 64'(bus.eng_cmd_valid), 64'(1));
         chk("issue_cmd_data", 64'(bus.eng_cmd_data), 64'(32'h0000_0100));
         step();
      end
      bus.eng_cmd_ready = 1'b1;
      wait_idle("stall_idle");

      // Requester 1 holds off its result 3 cycles while 3 waits; others' rsp_ready ignored
      bus.rsp_ready = 4'b1101;
      fork
         send(1, 32'h1234_5678, 32'hEDCB_A987, 1'b0, 7, 1'b1);
         send(3, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, -1, 1'b1);
         begin
            bit seen;
            seen = 1'b0;
            for (int n = 0; n < 100 && !seen; n++) begin
               #2;
               if (bus.rsp_valid[1]) seen = 1'b1;
               else step();
            end
            if (!seen) begin
               fail("hold_seen");
               step();
            end else begin
               for (int k = 0; k < 3; k++) begin
                  if (k > 0) begin step(); #2; end
                  chk("hold_rsp_valid", 64'(bus.rsp_valid), 64'(4'b0010));
                  chk("hold_req_ready", 64'(bus.req_ready), 64'(0));
                  chk("hold_rsp_data", 64'(bus.rsp_data), 64'(32'hEDCB_A987));
               end
               step();
            end
            bus.rsp_ready = 4'b1111;
         end
      join
      wait_idle("hold_idle");

      // Result one cycle before and exactly on the watchdog cycle
      stub_lat = TIMEOUT - 1;
      send(3, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 9, 1'b1);
      wait_idle("edge7_idle");
      stub_lat = TIMEOUT;
      send(2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 10, 1'b1);
      wait_idle("edge8_idle");

      // Reset while WAITing abandons the operation
      stub_lat = -1;
      send(0, 32'h0000_ABCD, 32'h0, 1'b0, -1, 1'b0);
      step(); step(); step();
      reset = 1'b1;
      #2;
      chk("mid_rst_req_ready", 64'(bus.req_ready), 64'(0));
      chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      chk("mid_rst_rsp_data", 64'(bus.rsp_data), 64'(0));
      chk("mid_rst_rsp_err", 64'(bus.rsp_err), 64'(0));
      chk("mid_rst_cmd_valid", 64'(bus.eng_cmd_valid), 64'(0));
      chk("mid_rst_cmd_data", 64'(bus.eng_cmd_data), 64'(0));
      chk("mid_rst_eng_rsp_ready", 64'(bus.eng_rsp_ready), 64'(0));
      chk("mid_rst_busy", 64'(bus.busy), 64'(0));
      chk("mid_rst_drop", 64'(bus.drop_count), 64'(0));
      step();
      reset = 1'b0;
      #2;
      chk("post_rst_busy", 64'(bus.busy), 64'(0));
      step();

      // Pointer restarted at 0: requester 1 is served before 3
      stub_lat = 5;
      push_exp(1, 32'hFFFF_FF00, 1'b0, -1);
      push_exp(3, 32'hFFFF_FFC3, 1'b0, -1);
      fork
         send(1, 32'h0000_00FF, 32'h0, 1'b0, -1, 1'b0);
         send(3, 32'h0000_003C, 32'h0, 1'b0, -1, 1'b0);
      join
      wait_idle("final_idle");
      #2;
      chk("sb_drained", 64'(sb.size()), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
